// File: rtl/rotate_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rotate_seq_ctrl_pkg
// Purpose  : Shared definitions for the rotate sequencer: controller state
//            encoding and rotate-direction constants.
// Contents : state_t   - IDLE / ROT / DONE controller states
//            DIR_LEFT  - rotate toward MSB, MSB wraps into bit 0
//            DIR_RIGHT - rotate toward LSB, bit 0 wraps into MSB
// Revision : 1.0 - initial release
// ============================================================================
package rotate_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ROT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage : rotate_seq_ctrl_pkg
`default_nettype wire

// File: rtl/rot_reg_en.sv
`default_nettype none
// ============================================================================
// Module   : rot_reg_en
// Purpose  : WIDTH-bit rotate register with clear, load and shift enable.
//            Priority is clear > load > shift > hold.
// Ports    : clk_i   - clock, rising edge
//            rst_ni  - asynchronous active-low reset (register -> 0)
//            clr_i   - synchronous clear
//            load_i  - load data_i
//            shift_i - rotate one position in direction dir_i
//            dir_i   - DIR_LEFT / DIR_RIGHT
//            data_i  - load value
//            q_o     - register contents
// Revision : 1.0 - initial release
// ============================================================================
module rot_reg_en
  import rotate_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= data_i;
    end else if (shift_i) begin
      if (dir_i == DIR_LEFT) begin
        data_q <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      end else begin
        data_q <= {data_q[0], data_q[WIDTH-1:1]};
      end
    end
  end

  assign q_o = data_q;

endmodule : rot_reg_en
`default_nettype wire

// File: rtl/rotate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rotate_seq_ctrl
// Purpose  : Sequencer for the circular shift datapath. Accepts a word, a
//            rotate amount and a direction over valid/ready, rotates the word
//            one step per cycle, and presents the result over valid/ready.
// Ports    : clk        - clock, rising edge
//            reset_n    - asynchronous active-low reset
//            abort      - synchronous abort, highest priority
//            req_valid  / req_ready  - request handshake
//            req_data   - word to rotate
//            req_amt    - rotate steps 0..WIDTH-1
//            req_dir    - 0 = left, 1 = right
//            res_valid  / res_ready  - result handshake
//            res_data   - rotated word (registered)
//            busy       - controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module rotate_seq_ctrl
  import rotate_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             abort,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_dir,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam logic [AMT_W-1:0] c_CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] c_CNT_ZERO = '0;

  state_t           state_q;
  logic [AMT_W-1:0] cnt_q;
  logic             dir_q;
  logic             res_valid_q;
  logic             busy_q;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_shift;

  // A consumer taking the result in DONE frees the slot on the same edge,
  // which is what allows back-to-back transactions.
  assign w_req_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && res_ready);

  // Abort wins over everything, including a request that sees ready high.
  assign w_accept    = req_valid && w_req_ready && !abort;
  assign w_shift     = (state_q == S_ROT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (abort) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (w_accept) begin
      // Reachable from IDLE and from DONE (back-to-back).
      cnt_q  <= req_amt;
      dir_q  <= req_dir;
      busy_q <= 1'b1;
      if (req_amt == c_CNT_ZERO) begin
        state_q     <= S_DONE;
        res_valid_q <= 1'b1;
      end else begin
        state_q     <= S_ROT;
        res_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        S_ROT: begin
          cnt_q <= cnt_q - c_CNT_ONE;
          // Counter at one means this edge performs the final rotate step.
          if (cnt_q == c_CNT_ONE) begin
            state_q     <= S_DONE;
            res_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  rot_reg_en #(
    .WIDTH (WIDTH)
  ) u_rot_reg (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .clr_i   (abort),
    .load_i  (w_accept),
    .shift_i (w_shift),
    .dir_i   (dir_q),
    .data_i  (req_data),
    .q_o     (res_data)
  );

  assign req_ready = w_req_ready;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

endmodule : rotate_seq_ctrl
`default_nettype wire

// File: tb/tb_rotate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotate_seq_ctrl
// Purpose  : Self-checking bench for rotate_seq_ctrl: a table of directed
//            transactions, hand-written corner sequences (back-to-back,
//            abort, asynchronous reset), and randomized traffic compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotate_seq_ctrl;

  logic       clk;
  logic       reset_n;
  logic       abort;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [2:0] req_amt;
  logic       req_dir;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  rotate_seq_ctrl #(
    .WIDTH (8),
    .AMT_W (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .abort     (abort),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [7:0] exp;
    int         hold;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rotate: duplicate the word and take a window.
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int n, input logic dr);
    logic [15:0] t;
    t = {d, d};
    if (dr == 1'b0) begin
      t = t << n;
      return t[15:8];
    end else begin
      t = t >> n;
      return t[7:0];
    end
  endfunction

  // One full transaction from IDLE: accept, measure latency, optional
  // backpressure, consume, and confirm return to idle.
  task automatic do_txn(input logic [7:0] d, input logic [2:0] n, input logic dr,
                        input logic [7:0] exp, input int hold);
    int k;
    @(negedge clk);
    check("idle req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_data = d; req_amt = n; req_dir = dr; res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("busy after accept", 32'(busy), 32'd1);
    k = 0;
    while (!res_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(n));
    check("res_data", 32'(res_data), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("bp res_valid", 32'(res_valid), 32'd1);
      check("bp res_data", 32'(res_data), 32'(exp));
      check("bp req_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    #1;
    check("done req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    res_ready = 1'b0;
    check("busy after consume", 32'(busy), 32'd0);
    check("valid after consume", 32'(res_valid), 32'd0);
  endtask

  vec_t tbl[8];

  bit         m_busy;
  int         m_rem;
  logic [7:0] m_res;
  logic       exp_rdy;
  int         k;

  initial begin
    tbl[0] = '{data: 8'h81, amt: 3'd1, dir: 1'b0, exp: 8'h03, hold: 0};
    tbl[1] = '{data: 8'hA5, amt: 3'd0, dir: 1'b0, exp: 8'hA5, hold: 0};
    tbl[2] = '{data: 8'h01, amt: 3'd3, dir: 1'b1, exp: 8'h20, hold: 5};
    tbl[3] = '{data: 8'hF0, amt: 3'd7, dir: 1'b0, exp: 8'h78, hold: 0};
    tbl[4] = '{data: 8'hC3, amt: 3'd4, dir: 1'b1, exp: 8'h3C, hold: 2};
    tbl[5] = '{data: 8'h12, amt: 3'd4, dir: 1'b0, exp: 8'h21, hold: 0};
    tbl[6] = '{data: 8'hB4, amt: 3'd2, dir: 1'b1, exp: 8'h2D, hold: 1};
    tbl[7] = '{data: 8'h80, amt: 3'd7, dir: 1'b1, exp: 8'h01, hold: 0};

    reset_n = 1'b0; abort = 1'b0; req_valid = 1'b0; req_data = '0;
    req_amt = '0; req_dir = 1'b0; res_ready = 1'b0;

    // Reset state
    #12;
    check("rst res_valid", 32'(res_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst res_data", 32'(res_data), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_txn(tbl[i].data, tbl[i].amt, tbl[i].dir, tbl[i].exp, tbl[i].hold);
    end

    // Back-to-back: consume 03 and accept F0/7/left on the same edge
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'h81; req_amt = 3'd1; req_dir = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b first valid", 32'(res_valid), 32'd1);
    check("b2b first data", 32'(res_data), 32'h03);
    res_ready = 1'b1; req_valid = 1'b1; req_data = 8'hF0; req_amt = 3'd7; req_dir = 1'b0;
    #1;
    check("b2b req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; res_ready = 1'b0;
    check("b2b valid drop", 32'(res_valid), 32'd0);
    check("b2b busy", 32'(busy), 32'd1);
    k = 0;
    while (!res_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b2b latency", 32'(k), 32'd7);
    check("b2b data", 32'(res_data), 32'h78);
    // Back-to-back with zero amount keeps res_valid high
    res_ready = 1'b1; req_valid = 1'b1; req_data = 8'hA5; req_amt = 3'd0; req_dir = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; res_ready = 1'b0;
    check("b2b0 valid", 32'(res_valid), 32'd1);
    check("b2b0 data", 32'(res_data), 32'hA5);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("b2b0 idle", 32'(busy), 32'd0);

    // Abort on the third ROT cycle, with a request also presented
    @(negedge clk);
    req_valid = 1'b1; req_data = 8'hC3; req_amt = 3'd6; req_dir = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1; req_valid = 1'b1; req_data = 8'h55; req_amt = 3'd0;
    @(negedge clk);
    abort = 1'b0; req_valid = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort res_valid", 32'(res_valid), 32'd0);
    check("abort res_data", 32'(res_data), 32'd0);
    check("abort req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort no result", 32'(res_valid), 32'd0);
    end
    // Abort in IDLE blocks a simultaneous request
    abort = 1'b1; req_valid = 1'b1; req_data = 8'h3C; req_amt = 3'd0;
    @(negedge clk);
    abort = 1'b0; req_valid = 1'b0;
    check("abort idle busy", 32'(busy), 32'd0);
    check("abort idle valid", 32'(res_valid), 32'd0);

    // Asynchronous reset mid-ROT
    req_valid = 1'b1; req_data = 8'hC3; req_amt = 3'd5; req_dir = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst res_valid", 32'(res_valid), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst res_data", 32'(res_data), 32'd0);
    check("arst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    do_txn(8'h80, 3'd1, 1'b0, 8'h01, 0);

    // Randomized traffic against a transaction-level model
    m_busy = 1'b0; m_rem = 0; m_res = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      check("rnd res_valid", 32'(res_valid), 32'(m_busy && m_rem == 0));
      check("rnd busy", 32'(busy), 32'(m_busy));
      if (m_busy && m_rem == 0) check("rnd res_data", 32'(res_data), 32'(m_res));
      abort     = ($urandom_range(0, 19) == 0);
      req_valid = 1'($urandom);
      req_data  = 8'($urandom);
      req_amt   = 3'($urandom);
      req_dir   = 1'($urandom);
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !m_busy || (m_rem == 0 && res_ready);
      check("rnd req_ready", 32'(req_ready), 32'(exp_rdy));
      if (abort) begin
        m_busy = 1'b0;
      end else if (req_valid && exp_rdy) begin
        m_busy = 1'b1;
        m_rem  = int'(req_amt);
        m_res  = ref_rot(req_data, int'(req_amt), req_dir);
      end else if (m_busy && m_rem > 0) begin
        m_rem--;
      end else if (m_busy && res_ready) begin
        m_busy = 1'b0;
      end
    end
    @(negedge clk);
    abort = 1'b0; req_valid = 1'b0; res_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_rotate_seq_ctrl
`default_nettype wire
